// File: rtl/axis_tag_strip.sv
// rtl/axis_tag_strip.sv - strips a leading tag from each frame and forwards the payload
module axis_tag_strip #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  m_tag_valid,
    output logic                  error_short_frame,
    output logic                  busy
);

    localparam int TAG_WORD_WIDTH = (TAG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PTR_WIDTH      = (TAG_WORD_WIDTH > 1) ? $clog2(TAG_WORD_WIDTH) : 1;
    localparam int SHIFT_WIDTH    = TAG_WORD_WIDTH * DATA_WIDTH;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(TAG_WORD_WIDTH - 1);

    typedef enum logic {
        STATE_TAG,
        STATE_TRANSFER
    } state_t;

    state_t                  state_reg, state_next;
    logic [PTR_WIDTH-1:0]    ptr_reg, ptr_next;
    logic [SHIFT_WIDTH-1:0]  tag_shift_reg, tag_shift_next;
    logic [TAG_WIDTH-1:0]    m_tag_reg, m_tag_next;
    logic                    m_tag_valid_reg, m_tag_valid_next;
    logic                    error_reg, error_next;
    logic                    busy_reg, busy_next;
    logic                    s_ready_reg, s_ready_next;

    // Output stage: main register plus skid register. out_ready_reg is the
    // stage's own registered ready; while stripping a tag the input ready is
    // forced high, so the stage cannot rely on s_ready_reg for its invariant.
    logic                    out_ready_reg, out_ready_next;
    logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
    logic                    m_valid_reg, m_valid_next;
    logic                    m_last_reg, m_last_next;
    logic                    m_user_reg, m_user_next;
    logic [DATA_WIDTH-1:0]   temp_data_reg, temp_data_next;
    logic                    temp_valid_reg, temp_valid_next;
    logic                    temp_last_reg, temp_last_next;
    logic                    temp_user_reg, temp_user_next;

    logic s_fire;
    logic push;
    logic early_ready;

    assign s_fire      = s_axis_tvalid && s_ready_reg;
    assign push        = s_fire && (state_reg == STATE_TRANSFER);
    assign early_ready = m_axis_tready || (!temp_valid_reg && (!m_valid_reg || !push));

    assign s_axis_tready     = s_ready_reg;
    assign m_axis_tdata      = m_data_reg;
    assign m_axis_tvalid     = m_valid_reg;
    assign m_axis_tlast      = m_last_reg;
    assign m_axis_tuser      = m_user_reg;
    assign m_tag             = m_tag_reg;
    assign m_tag_valid       = m_tag_valid_reg;
    assign error_short_frame = error_reg;
    assign busy              = busy_reg;

    // Next-state logic: tag assembly, frame FSM and input ready selection
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        tag_shift_next   = tag_shift_reg;
        m_tag_next       = m_tag_reg;
        m_tag_valid_next = 1'b0;
        error_next       = 1'b0;
        s_ready_next     = 1'b1;

        case (state_reg)
            STATE_TAG: begin
                s_ready_next = 1'b1;
                if (s_fire) begin
                    tag_shift_next[int'(ptr_reg)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                    if (s_axis_tlast) begin
                        // Frame ended before any payload: drop it and restart.
                        error_next = 1'b1;
                        ptr_next   = '0;
                    end else if (ptr_reg == PTR_LAST) begin
                        m_tag_next       = tag_shift_next[TAG_WIDTH-1:0];
                        m_tag_valid_next = 1'b1;
                        ptr_next         = '0;
                        state_next       = STATE_TRANSFER;
                        s_ready_next     = early_ready;
                    end else begin
                        ptr_next = ptr_reg + 1'b1;
                    end
                end
            end
            STATE_TRANSFER: begin
                s_ready_next = early_ready;
                if (s_fire && s_axis_tlast) begin
                    // Next frame's tag does not need output space, so accept it at once.
                    state_next   = STATE_TAG;
                    s_ready_next = 1'b1;
                end
            end
        endcase

        busy_next = (state_next == STATE_TRANSFER) || (ptr_next != '0);
    end

    // Output stage steering between input, main and skid registers
    always_comb begin
        out_ready_next  = early_ready;
        m_data_next     = m_data_reg;
        m_valid_next    = m_valid_reg;
        m_last_next     = m_last_reg;
        m_user_next     = m_user_reg;
        temp_data_next  = temp_data_reg;
        temp_valid_next = temp_valid_reg;
        temp_last_next  = temp_last_reg;
        temp_user_next  = temp_user_reg;

        if (out_ready_reg) begin
            // Skid register is known empty whenever out_ready_reg is high.
            if (m_axis_tready || !m_valid_reg) begin
                m_valid_next = push;
                if (push) begin
                    m_data_next = s_axis_tdata;
                    m_last_next = s_axis_tlast;
                    m_user_next = s_axis_tuser;
                end
            end else begin
                temp_valid_next = push;
                if (push) begin
                    temp_data_next = s_axis_tdata;
                    temp_last_next = s_axis_tlast;
                    temp_user_next = s_axis_tuser;
                end
            end
        end else if (m_axis_tready) begin
            m_valid_next    = temp_valid_reg;
            m_data_next     = temp_data_reg;
            m_last_next     = temp_last_reg;
            m_user_next     = temp_user_reg;
            temp_valid_next = 1'b0;
        end
    end

    // State register for the FSM, tag path and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= STATE_TAG;
            ptr_reg         <= '0;
            tag_shift_reg   <= '0;
            m_tag_reg       <= '0;
            m_tag_valid_reg <= 1'b0;
            error_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            s_ready_reg     <= 1'b0;
            out_ready_reg   <= 1'b0;
            m_data_reg      <= '0;
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            m_user_reg      <= 1'b0;
            temp_data_reg   <= '0;
            temp_valid_reg  <= 1'b0;
            temp_last_reg   <= 1'b0;
            temp_user_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            tag_shift_reg   <= tag_shift_next;
            m_tag_reg       <= m_tag_next;
            m_tag_valid_reg <= m_tag_valid_next;
            error_reg       <= error_next;
            busy_reg        <= busy_next;
            s_ready_reg     <= s_ready_next;
            out_ready_reg   <= out_ready_next;
            m_data_reg      <= m_data_next;
            m_valid_reg     <= m_valid_next;
            m_last_reg      <= m_last_next;
            m_user_reg      <= m_user_next;
            temp_data_reg   <= temp_data_next;
            temp_valid_reg  <= temp_valid_next;
            temp_last_reg   <= temp_last_next;
            temp_user_reg   <= temp_user_next;
        end
    end

endmodule
